// File: rtl/adder_bist.sv
// -----------------------------------------------------------------------------
// adder_bist
//
// Built-in self-test sequencer for an external 1-bit full adder. On a start
// request it walks all eight {a,b,c} input combinations in ascending order.
// For each one it drives the vector, waits SETTLE_CYCLES cycles, then compares
// the adder response with the golden full-adder function.
//
// Parameters
//   SETTLE_CYCLES  cycles between applying a vector and sampling (1..15)
//
// Ports
//   clk                 single clock, rising edge
//   rst_n               asynchronous active-low reset
//   start               begin a run (accepted only in IDLE)
//   vec_a/vec_b/vec_c   stimulus to the external adder
//   dut_sum/dut_cout    response from the external adder
//   busy                high in every state except IDLE
//   done                one-cycle pulse at run completion
//   pass                result of the last completed run
//   err_count           mismatching vectors (saturates at 8)
//   vec_idx             index of the vector under test
//
// Optional feature (macro ADDER_BIST_ERRLOG_EN):
//   first_fail_valid    a mismatch has been seen in this run
//   first_fail_vec      vector index of the first mismatch
//
// Handshake: start is a level sampled on the rising edge; it is acted on only
// when the FSM is in IDLE and is silently dropped in every other state.
// -----------------------------------------------------------------------------
module adder_bist #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       vec_a,
   output logic       vec_b,
   output logic       vec_c,
   input  logic       dut_sum,
   input  logic       dut_cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] vec_idx
`ifdef ADDER_BIST_ERRLOG_EN
   ,
   output logic       first_fail_valid,
   output logic [2:0] first_fail_vec
`endif
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
   localparam logic [3:0] ERR_MAX     = 4'd8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] settle_cnt;
   logic       exp_sum;
   logic       exp_cout;
   logic       mismatch;
   logic [3:0] err_nxt;

   // Golden full-adder response for the vector currently held in vec_idx.
   // The case-inequality makes an X/Z response count as a mismatch.
   always_comb begin
      exp_sum  = vec_idx[2] ^ vec_idx[1] ^ vec_idx[0];
      exp_cout = (vec_idx[2] & vec_idx[1]) | (vec_idx[2] & vec_idx[0]) |
                 (vec_idx[1] & vec_idx[0]);
      mismatch = (dut_sum !== exp_sum) || (dut_cout !== exp_cout);
      err_nxt  = err_count;
      if (mismatch && (err_count != ERR_MAX)) begin
         err_nxt = err_count + 4'd1;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = APPLY;
         APPLY:   state_nxt = SETTLE;
         // Counter is loaded with SETTLE_CYCLES in APPLY, so leaving when it
         // reads 1 gives exactly SETTLE_CYCLES cycles in this state.
         SETTLE:  if (settle_cnt <= 4'd1) state_nxt = CHECK;
         CHECK:   state_nxt = (vec_idx == 3'd7) ? DONE : APPLY;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_idx    <= 3'd0;
         err_count  <= 4'd0;
         pass       <= 1'b0;
         settle_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  vec_idx   <= 3'd0;
                  err_count <= 4'd0;
               end
            end
            APPLY:  settle_cnt <= SETTLE_LOAD;
            SETTLE: settle_cnt <= settle_cnt - 4'd1;
            CHECK: begin
               err_count <= err_nxt;
               if (vec_idx == 3'd7) begin
                  // Result is registered on entry to DONE so it is already
                  // valid during the done pulse.
                  pass <= (err_nxt == 4'd0);
               end else begin
                  vec_idx <= vec_idx + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ADDER_BIST_ERRLOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_fail_valid <= 1'b0;
         first_fail_vec   <= 3'd0;
      end else if ((state == IDLE) && start) begin
         first_fail_valid <= 1'b0;
         first_fail_vec   <= 3'd0;
      end else if ((state == CHECK) && mismatch && !first_fail_valid) begin
         first_fail_valid <= 1'b1;
         first_fail_vec   <= vec_idx;
      end
   end
`endif

   // Outputs: stimulus is only driven while a vector is in flight.
   always_comb begin
      busy  = (state != IDLE);
      done  = (state == DONE);
      vec_a = 1'b0;
      vec_b = 1'b0;
      vec_c = 1'b0;
      if ((state == APPLY) || (state == SETTLE) || (state == CHECK)) begin
         {vec_a, vec_b, vec_c} = vec_idx;
      end
   end

endmodule

// File: tb/tb_adder_bist.sv
// -----------------------------------------------------------------------------
// tb_adder_bist
//
// Bench for adder_bist. Instance u_dut (SETTLE_CYCLES=1) drives a behavioural
// full adder with selectable faults; instance u_dut3 (SETTLE_CYCLES=3) drives
// a full adder whose response lags its inputs by two cycles. Expected run
// results and vector sequences are queued when a start is driven and popped
// when the design reports them.
// -----------------------------------------------------------------------------
module tb_adder_bist;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- DUT 1: SETTLE_CYCLES = 1 ----------------
   logic       start;
   logic       vec_a, vec_b, vec_c;
   logic       dut_sum, dut_cout;
   logic       busy, done, pass;
   logic [3:0] err_count;
   logic [2:0] vec_idx;
   logic [1:0] fault;   // 0 good, 1 cout stuck-at-0, 2 sum inverted
`ifdef ADDER_BIST_ERRLOG_EN
   logic       ffv;
   logic [2:0] ffvec;
`endif

   assign dut_sum  = (fault == 2'd2) ? ~(vec_a ^ vec_b ^ vec_c) : (vec_a ^ vec_b ^ vec_c);
   assign dut_cout = (fault == 2'd1) ? 1'b0 :
                     ((vec_a & vec_b) | (vec_a & vec_c) | (vec_b & vec_c));

   adder_bist #(.SETTLE_CYCLES(1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .vec_a     (vec_a),
      .vec_b     (vec_b),
      .vec_c     (vec_c),
      .dut_sum   (dut_sum),
      .dut_cout  (dut_cout),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .vec_idx   (vec_idx)
`ifdef ADDER_BIST_ERRLOG_EN
      ,
      .first_fail_valid (ffv),
      .first_fail_vec   (ffvec)
`endif
   );

   // ---------------- DUT 3: SETTLE_CYCLES = 3, 2-cycle adder ----------------
   logic       start3;
   logic       v3a, v3b, v3c;
   logic       busy3, done3, pass3;
   logic [3:0] err3;
   logic [2:0] idx3;
   logic [1:0] d1 = 2'b00;
   logic [1:0] d2 = 2'b00;
`ifdef ADDER_BIST_ERRLOG_EN
   logic       ffv3;
   logic [2:0] ffvec3;
`endif

   always @(posedge clk) begin
      d1 <= {v3a ^ v3b ^ v3c, (v3a & v3b) | (v3a & v3c) | (v3b & v3c)};
      d2 <= d1;
   end

   adder_bist #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start3),
      .vec_a     (v3a),
      .vec_b     (v3b),
      .vec_c     (v3c),
      .dut_sum   (d2[1]),
      .dut_cout  (d2[0]),
      .busy      (busy3),
      .done      (done3),
      .pass      (pass3),
      .err_count (err3),
      .vec_idx   (idx3)
`ifdef ADDER_BIST_ERRLOG_EN
      ,
      .first_fail_valid (ffv3),
      .first_fail_vec   (ffvec3)
`endif
   );

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [3:0] err;
      logic       pass;
      logic [7:0] lat;
      logic       ffv;
      logic [2:0] ffvec;
   } exp_t;

   exp_t       res_q[$];
   exp_t       res3_q[$];
   logic [2:0] vec_q[$];
   int         t0 = 0;
   int         t3 = 0;
   int         n_cmp = 0;
   int         n_mis = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // DUT 1 monitor: vector sequence and run results
   logic       prev_busy = 1'b0;
   logic [2:0] prev_idx  = 3'd0;
   always @(negedge clk) begin
      exp_t       e;
      logic [2:0] ev;
      if (busy && !done && (!prev_busy || (vec_idx != prev_idx))) begin
         if (vec_q.size() == 0) begin
            check("vec_unexpected", 0, 1);
         end else begin
            ev = vec_q.pop_front();
            check("vec_idx", vec_idx, ev);
            check("vec_pins", {vec_a, vec_b, vec_c}, ev);
         end
      end
      if (done) begin
         if (res_q.size() == 0) begin
            check("done_unexpected", 0, 1);
         end else begin
            e = res_q.pop_front();
            check("err_count", err_count, e.err);
            check("pass", pass, e.pass);
            check("latency", cyc - t0, e.lat);
`ifdef ADDER_BIST_ERRLOG_EN
            check("first_fail_valid", ffv, e.ffv);
            check("first_fail_vec", ffvec, e.ffvec);
`endif
         end
      end
      prev_busy = busy;
      prev_idx  = vec_idx;
   end

   // DUT 3 monitor: run results only
   always @(negedge clk) begin
      exp_t e;
      if (done3) begin
         if (res3_q.size() == 0) begin
            check("done3_unexpected", 0, 1);
         end else begin
            e = res3_q.pop_front();
            check("err3", err3, e.err);
            check("pass3", pass3, e.pass);
            check("latency3", cyc - t3, e.lat);
`ifdef ADDER_BIST_ERRLOG_EN
            check("first_fail_valid3", ffv3, e.ffv);
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Pulse start for one edge and queue the expected outcome of the run.
   task automatic run_bist(input logic [3:0] e_err, input logic e_pass,
                           input logic e_ffv, input logic [2:0] e_ffvec);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      t0    = cyc;
      e     = '{err: e_err, pass: e_pass, lat: 8'd25, ffv: e_ffv, ffvec: e_ffvec};
      res_q.push_back(e);
      for (int i = 0; i < 8; i++) vec_q.push_back(3'(i));
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("busy_after_start", busy, 1);
      check("err_cleared", err_count, 0);
   endtask

   task automatic run_bist3;
      exp_t e;
      @(negedge clk);
      start3 = 1'b1;
      t3     = cyc;
      e      = '{err: 4'd0, pass: 1'b1, lat: 8'd41, ffv: 1'b0, ffvec: 3'd0};
      res3_q.push_back(e);
      @(posedge clk);
      #1 start3 = 1'b0;
   endtask

   // Wait (bounded) until every queued run has reported.
   task automatic wait_drain(input int budget);
      int n = 0;
      while (((res_q.size() + res3_q.size()) != 0) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", res_q.size() + res3_q.size(), 0);
      check("vec_left", vec_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_err"}, err_count, 0);
      check({tag, "_idx"}, vec_idx, 0);
      check({tag, "_pins"}, {vec_a, vec_b, vec_c}, 0);
`ifdef ADDER_BIST_ERRLOG_EN
      check({tag, "_ffv"}, ffv, 0);
`endif
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      start3 = 1'b0;
      fault  = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      check("reset_busy3", busy3, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Good adder
      run_bist(4'd0, 1'b1, 1'b0, 3'd0);
      wait_drain(100);

      // Carry stuck at 0: vectors 3,5,6,7 fail
      fault = 2'd1;
      run_bist(4'd4, 1'b0, 1'b1, 3'd3);
      wait_drain(100);
      check("pass_hold_fail", pass, 0);
      check("err_hold", err_count, 4);

      // Good again: pass returns to 1
      fault = 2'd0;
      run_bist(4'd0, 1'b1, 1'b0, 3'd0);
      wait_drain(100);
      check("pass_hold_ok", pass, 1);

      // Sum inverted: every vector fails, count stops at 8
      fault = 2'd2;
      run_bist(4'd8, 1'b0, 1'b1, 3'd0);
      wait_drain(100);

      // Start re-pulsed mid-run is ignored
      fault = 2'd0;
      run_bist(4'd0, 1'b1, 1'b0, 3'd0);
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_drain(100);
      repeat (30) @(negedge clk);

      // Start during the DONE cycle is ignored
      run_bist(4'd0, 1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) break;
      end
      check("done_seen", done, 1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("start_in_done_busy", busy, 0);
      repeat (30) @(negedge clk);
      wait_drain(10);

      // Reset in the middle of a failing run
      fault = 2'd2;
      run_bist(4'd8, 1'b0, 1'b1, 3'd0);
      repeat (11) @(negedge clk);
      check("err_midrun", err_count, 3);
      #2 rst_n = 1'b0;
      res_q.delete();
      vec_q.delete();
      #1 check_reset_outputs("async_reset");
      @(posedge clk);
      #1 check_reset_outputs("held_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("no_restart_busy", busy, 0);
      fault = 2'd0;
      run_bist(4'd0, 1'b1, 1'b0, 3'd0);
      wait_drain(100);

      // Longer settle with a slow adder
      run_bist3();
      wait_drain(100);
      @(negedge clk);
      check("done3_single", done3, 0);
      check("busy3_idle", busy3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   // Absolute watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
